// File: rtl/razor_pkg.sv
// Shared types and constants for the Razor error-recovery controller.
package razor_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESTORE = 2'd1,
        REPLAY  = 2'd2
    } razor_state_e;

    localparam int unsigned ERR_TOTAL_W = 16;
    localparam logic [ERR_TOTAL_W-1:0] ERR_TOTAL_MAX = '1;

endpackage

// File: rtl/razor_dvs_window.sv
// Windowed error counter that steps the supply voltage code up or down
// once per observation window.
module razor_dvs_window
    import razor_pkg::*;
#(
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned VCODE_W   = 6,
    parameter int unsigned VCODE_RST = 32,
    parameter int unsigned ERR_HI    = 4,
    parameter int unsigned ERR_LO    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               det,
    output logic [VCODE_W-1:0] vcode,
    output logic               vcode_min,
    output logic               vcode_max
);

    localparam int unsigned CNT_W = $clog2(WINDOW);
    localparam int unsigned WE_W  = $clog2(ERR_HI + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [WE_W-1:0]    HI       = WE_W'(ERR_HI);
    localparam logic [WE_W-1:0]    LO       = WE_W'(ERR_LO);
    localparam logic [VCODE_W-1:0] VRST     = VCODE_W'(VCODE_RST);

    logic [CNT_W-1:0]   win_cnt;
    logic [WE_W-1:0]    win_err;
    logic [WE_W-1:0]    eff;
    logic [WE_W:0]      sum;
    logic               close;
    logic [VCODE_W-1:0] vcode_nxt;

    // Saturating error tally including this cycle's detection, and the
    // voltage step decided on it when the window closes.
    always_comb begin
        sum       = {1'b0, win_err} + (WE_W+1)'(det);
        eff       = (sum >= {1'b0, HI}) ? HI : sum[WE_W-1:0];
        close     = (win_cnt == CNT_LAST);
        vcode_nxt = vcode;
        if (close) begin
            if (eff >= HI) begin
                if (vcode != '1) vcode_nxt = vcode + VCODE_W'(1);
            end else if (eff <= LO) begin
                if (vcode != '0) vcode_nxt = vcode - VCODE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt   <= '0;
            win_err   <= '0;
            vcode     <= VRST;
            vcode_min <= (VRST == '0);
            vcode_max <= (VRST == '1);
        end else begin
            win_cnt   <= win_cnt + CNT_W'(1);
            win_err   <= close ? '0 : eff;
            vcode     <= vcode_nxt;
            vcode_min <= (vcode_nxt == '0);
            vcode_max <= (vcode_nxt == '1);
        end
    end

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor error detection, fixed two-cycle stall/restore/replay recovery and
// closed-loop supply voltage tuning.
module razor_recovery_ctrl
    import razor_pkg::*;
#(
    parameter int unsigned N_ERR     = 32,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned VCODE_W   = 6,
    parameter int unsigned VCODE_RST = 32,
    parameter int unsigned ERR_HI    = 4,
    parameter int unsigned ERR_LO    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_ERR-1:0]   err_in,
    input  logic               op_valid,
    output logic               stall,
    output logic               restore,
    output logic               replay,
    output logic [VCODE_W-1:0] vcode,
    output logic               vcode_min,
    output logic               vcode_max,
    output logic [15:0]        err_total
);

    razor_state_e state, state_nxt;
    logic stall_nxt, restore_nxt, replay_nxt;
    logic det;

    // Errors are ignored while the shadow value is being restored/replayed.
    assign det = (state == RUN) & op_valid & (|err_in);

    always_comb begin
        state_nxt   = state;
        stall_nxt   = 1'b0;
        restore_nxt = 1'b0;
        replay_nxt  = 1'b0;
        case (state)
            RUN:     if (det) state_nxt = RESTORE;
            RESTORE: state_nxt = REPLAY;
            REPLAY:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        case (state_nxt)
            RESTORE: begin
                stall_nxt   = 1'b1;
                restore_nxt = 1'b1;
            end
            REPLAY: begin
                stall_nxt  = 1'b1;
                replay_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall     <= 1'b0;
            restore   <= 1'b0;
            replay    <= 1'b0;
            err_total <= '0;
        end else begin
            state   <= state_nxt;
            stall   <= stall_nxt;
            restore <= restore_nxt;
            replay  <= replay_nxt;
            if (det && (err_total != ERR_TOTAL_MAX))
                err_total <= err_total + ERR_TOTAL_W'(1);
        end
    end

    razor_dvs_window #(
        .WINDOW    (WINDOW),
        .VCODE_W   (VCODE_W),
        .VCODE_RST (VCODE_RST),
        .ERR_HI    (ERR_HI),
        .ERR_LO    (ERR_LO)
    ) u_dvs (
        .clk       (clk),
        .reset     (reset),
        .det       (det),
        .vcode     (vcode),
        .vcode_min (vcode_min),
        .vcode_max (vcode_max)
    );

endmodule
